// File: rtl/psram_arbiter.sv
// Three-port arbiter (loader / CPU / PPU) in front of a single byte-wide PSRAM controller.
// One pending slot per port, fixed priority ldr > ppu > cpu with a CPU starvation override.
module psram_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int STARVE_LIMIT = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_rdata,
  output logic              mc_read_a,
  output logic              mc_read_b,
  output logic              mc_write,
  output logic [23:0]       mc_addr,
  output logic [7:0]        mc_din,
  input  logic              mc_busy,
  input  logic [7:0]        mc_dout_a,
  input  logic [7:0]        mc_dout_b,
  output logic [2:0]        overrun,
  output logic              timeout
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WRISE = 2'd2, S_WFALL = 2'd3;
  localparam logic [1:0] P_LDR = 2'd0, P_CPU = 2'd1, P_PPU = 2'd2;
  localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
  localparam int WW  = $clog2(STARVE_LIMIT + 1);
  localparam int PAD = 24 - ADDR_W;

  logic [1:0]        state_q, state_d, win_q, win_d, win;
  logic [2:0]        pend_q, pend_d, ack_q, ack_d, ovr_q, ovr_d, win_oh;
  logic [ADDR_W-1:0] ldr_addr_q, ldr_addr_d, cpu_addr_q, cpu_addr_d, ppu_addr_q, ppu_addr_d, gaddr;
  logic [7:0]        ldr_wd_q, ldr_wd_d, cpu_wd_q, cpu_wd_d, crd_q, crd_d, prd_q, prd_d;
  logic              cpu_we_q, cpu_we_d;
  logic              rd_a_q, rd_a_d, rd_b_q, rd_b_d, wr_q, wr_d, to_q, to_d;
  logic [23:0]       addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [WW-1:0]     wait_q, wait_d;

  // Starved CPU jumps the queue; otherwise plain fixed priority.
  always_comb begin
    if (pend_q[P_CPU] && wait_q == WW'(STARVE_LIMIT)) win = P_CPU;
    else if (pend_q[P_LDR])                           win = P_LDR;
    else if (pend_q[P_PPU])                           win = P_PPU;
    else                                              win = P_CPU;
    case (win)
      P_LDR:   gaddr = ldr_addr_q;
      P_PPU:   gaddr = ppu_addr_q;
      default: gaddr = cpu_addr_q;
    endcase
  end

  assign win_oh = 3'b001 << win_q;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    pend_d     = pend_q;
    ack_d      = 3'b000;
    ovr_d      = ovr_q;
    ldr_addr_d = ldr_addr_q;
    ldr_wd_d   = ldr_wd_q;
    cpu_addr_d = cpu_addr_q;
    cpu_wd_d   = cpu_wd_q;
    cpu_we_d   = cpu_we_q;
    ppu_addr_d = ppu_addr_q;
    crd_d      = crd_q;
    prd_d      = prd_q;
    rd_a_d     = 1'b0;
    rd_b_d     = 1'b0;
    wr_d       = 1'b0;
    to_d       = to_q;
    addr_d     = addr_q;
    din_d      = din_q;
    tcnt_d     = tcnt_q;
    wait_d     = wait_q;
    case (state_q)
      S_IDLE: if (|pend_q && !mc_busy) begin
        win_d  = win;
        addr_d = {{PAD{1'b0}}, gaddr};
        din_d  = (win == P_LDR) ? ldr_wd_q : cpu_wd_q;
        wr_d   = (win == P_LDR) || (win == P_CPU && cpu_we_q);
        rd_a_d = (win == P_CPU) && !cpu_we_q;
        rd_b_d = (win == P_PPU);
        if (win == P_CPU) wait_d = '0;
        else if (pend_q[P_CPU] && wait_q != WW'(STARVE_LIMIT)) wait_d = wait_q + 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        state_d = S_WRISE;
      end
      S_WRISE: begin
        if (mc_busy) state_d = S_WFALL;
        else if (tcnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          to_d    = 1'b1;       // slot stays pending, so IDLE retries it
          state_d = S_IDLE;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      default: if (!mc_busy) begin
        ack_d  = win_oh;
        pend_d = pend_q & ~win_oh;
        if (win_q == P_CPU && !cpu_we_q) crd_d = mc_dout_a;
        if (win_q == P_PPU)              prd_d = mc_dout_b;
        state_d = S_IDLE;
      end
    endcase
    // Slot already cleared on the ack edge, so a req during the ack cycle is accepted.
    if (ldr_req) begin
      if (pend_q[P_LDR]) ovr_d[P_LDR] = 1'b1;
      else begin pend_d[P_LDR] = 1'b1; ldr_addr_d = ldr_addr; ldr_wd_d = ldr_wdata; end
    end
    if (cpu_req) begin
      if (pend_q[P_CPU]) ovr_d[P_CPU] = 1'b1;
      else begin
        pend_d[P_CPU] = 1'b1; cpu_addr_d = cpu_addr; cpu_wd_d = cpu_wdata; cpu_we_d = cpu_we;
      end
    end
    if (ppu_req) begin
      if (pend_q[P_PPU]) ovr_d[P_PPU] = 1'b1;
      else begin pend_d[P_PPU] = 1'b1; ppu_addr_d = ppu_addr; end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; win_q <= P_LDR; pend_q <= '0; ack_q <= '0; ovr_q <= '0;
      ldr_addr_q <= '0; ldr_wd_q <= '0; cpu_addr_q <= '0; cpu_wd_q <= '0; cpu_we_q <= 1'b0;
      ppu_addr_q <= '0; crd_q <= '0; prd_q <= '0;
      rd_a_q <= 1'b0; rd_b_q <= 1'b0; wr_q <= 1'b0; to_q <= 1'b0;
      addr_q <= '0; din_q <= '0; tcnt_q <= '0; wait_q <= '0;
    end else begin
      state_q <= state_d; win_q <= win_d; pend_q <= pend_d; ack_q <= ack_d; ovr_q <= ovr_d;
      ldr_addr_q <= ldr_addr_d; ldr_wd_q <= ldr_wd_d; cpu_addr_q <= cpu_addr_d;
      cpu_wd_q <= cpu_wd_d; cpu_we_q <= cpu_we_d; ppu_addr_q <= ppu_addr_d;
      crd_q <= crd_d; prd_q <= prd_d;
      rd_a_q <= rd_a_d; rd_b_q <= rd_b_d; wr_q <= wr_d; to_q <= to_d;
      addr_q <= addr_d; din_q <= din_d; tcnt_q <= tcnt_d; wait_q <= wait_d;
    end
  end

  assign ldr_ack   = ack_q[P_LDR];
  assign cpu_ack   = ack_q[P_CPU];
  assign ppu_ack   = ack_q[P_PPU];
  assign cpu_rdata = crd_q;
  assign ppu_rdata = prd_q;
  assign mc_read_a = rd_a_q;
  assign mc_read_b = rd_b_q;
  assign mc_write  = wr_q;
  assign mc_addr   = addr_q;
  assign mc_din    = din_q;
  assign overrun   = ovr_q;
  assign timeout   = to_q;
endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single byte-wide PSRAM memory controller between three requesters: the ROM loader (write only), the CPU (read/write) and the PPU (read only).
- Each requester gets a one-entry pending slot.
- Grants use fixed priority loader > PPU > CPU, with a starvation override for the CPU.
- The arbiter issues one-cycle strobes to the controller, tracks its busy handshake and returns a per-port ack pulse with read data.

Parameters:
- ADDR_W, 22, requester address width; mc_addr is zero-extended to 24 bits.
- STARVE_LIMIT, 4, consecutive non-CPU grants while the CPU is pending before the CPU becomes top priority.
- BUSY_TIMEOUT, 15, cycles in WAIT_RISE without mc_busy before the access is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ldr_req  in  1  one-cycle write request pulse.
- ldr_addr  in  ADDR_W  loader write address.
- ldr_wdata  in  8  loader write data.
- ldr_ack  out  1  one-cycle completion pulse.
- cpu_req  in  1  one-cycle request pulse.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  CPU read data, valid with cpu_ack and held until the next CPU read ack.
- ppu_req  in  1  one-cycle read request pulse.
- ppu_addr  in  ADDR_W  PPU address.
- ppu_ack  out  1  one-cycle completion pulse.
- ppu_rdata  out  8  PPU read data, valid with ppu_ack and held.
- mc_read_a  out  1  controller read strobe, CPU port.
- mc_read_b  out  1  controller read strobe, PPU port.
- mc_write  out  1  controller write strobe.
- mc_addr  out  24  equals {zero pad, granted addr}.
- mc_din  out  8  granted write data.
- mc_busy  in  1  controller busy.
- mc_dout_a  in  8  controller read data, CPU port.
- mc_dout_b  in  8  controller read data, PPU port.
- overrun  out  3  sticky {ppu, cpu, ldr}: req arrived while that slot was pending.
- timeout  out  1  sticky: busy never rose after an issue.

Behaviour:
- Reset clears:
  - all slots and the starvation counter;
  - state to IDLE;
  - all strobes, acks, rdata, mc_addr, mc_din, overrun and timeout to 0.
- Reset mid-access abandons the access without an ack. IDLE still waits for mc_busy==0 before granting.
- Capture:
  - On req, if the slot is empty, latch addr/wdata/we and mark the slot pending.
  - If the slot is pending, drop the req and set that port's overrun bit.
  - A req in the same cycle as that port's ack is accepted, because the slot frees on the ack edge.
- Registered-output FSM with states IDLE, ISSUE, WAIT_RISE, WAIT_FALL.
- IDLE:
  - Requires any slot pending and mc_busy==0.
  - Select winner: if cpu_wait==STARVE_LIMIT and the CPU is pending, the CPU wins. Otherwise the first pending of ldr, ppu, cpu wins.
  - Load mc_addr/mc_din and exactly one strobe, then go to ISSUE.
  - Strobe mapping: ldr → mc_write; cpu write → mc_write; cpu read → mc_read_a; ppu → mc_read_b.
- ISSUE: strobes are high for exactly this one cycle; clear them and go to WAIT_RISE with the timeout counter at 0.
- WAIT_RISE:
  - If mc_busy, go to WAIT_FALL.
  - Else increment the counter. At BUSY_TIMEOUT, set timeout and return to IDLE. The slot stays pending and is retried.
- WAIT_FALL, on the first cycle mc_busy==0:
  - Register the winner's ack=1.
  - Latch rdata: cpu_rdata from mc_dout_a, ppu_rdata from mc_dout_b.
  - Clear the winner's slot and go to IDLE.
- Acks last exactly one cycle. cpu_rdata is updated only on CPU reads.
- Starvation:
  - cpu_wait increments (saturating at STARVE_LIMIT) on each ldr/ppu grant made while the CPU is pending.
  - It clears on a CPU grant.
- Latency: with an idle system and a 3-cycle controller busy window, req in cycle T gives ack in cycle T+7. Back-to-back grants have at most 1 IDLE cycle between an ack and the next strobe.
- Simultaneous reqs on all ports in one cycle are all captured and served in priority order.

Test Plan:
- Single CPU read at addr 0x00123 (controller model returns 0x5A) → mc_read_a high one cycle with mc_addr=0x000123; cpu_ack exactly 7 cycles after cpu_req with cpu_rdata=0x5A.
- ldr, ppu and cpu reqs in the same cycle → grant order ldr, ppu, cpu; three single-cycle acks in that order; no overrun.
- PPU requests continuously re-issued the cycle after each ppu_ack while a CPU read is pending → the CPU is granted after exactly 4 PPU grants; cpu_wait then clears.
- Second cpu_req while the CPU slot is pending → overrun=3'b010; only one cpu_ack; the data is from the first address.
- Controller model never raises busy → after 15 WAIT_RISE cycles timeout=1, no ack, the request is reissued.
- Reset asserted during WAIT_FALL with mc_busy high → no ack, all outputs 0; the first post-reset request issues only after mc_busy falls.
